miss_mem_arbiter: RTL and testbench

//  Sits directly downstream of the icache and dcache miss ports. Arbitrates their line-fill and evict requests onto a single main-memory port.

---
 rtl/miss_mem_arbiter_if.sv | 43 ++++
 rtl/miss_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_miss_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/miss_mem_arbiter_if.sv
// Miss-port bundle between the icache/dcache miss ports, the arbiter and main memory.
// Modport slave is the arbiter's view; modport master is the caches'/memory's view.
interface miss_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned LINE_W = 128
);
    localparam int unsigned REQ_W = 1 + ADDR_W + LINE_W;

    logic              ic_req_valid;
    logic [REQ_W-1:0]  ic_req_info;
    logic              ic_rsp_valid;
    logic [LINE_W-1:0] ic_rsp_data;
    logic              ic_rsp_bus_error;

    logic              dc_req_valid;
    logic [REQ_W-1:0]  dc_req_info;
    logic              dc_rsp_valid;
    logic [LINE_W-1:0] dc_rsp_data;
    logic              dc_rsp_bus_error;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [REQ_W-1:0]  mem_req_info;
    logic              mem_rsp_valid;
    logic [LINE_W-1:0] mem_rsp_data;
    logic              mem_rsp_error;

    modport slave (
        input  ic_req_valid, ic_req_info, dc_req_valid, dc_req_info,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_error,
        output ic_rsp_valid, ic_rsp_data, ic_rsp_bus_error,
        output dc_rsp_valid, dc_rsp_data, dc_rsp_bus_error,
        output mem_req_valid, mem_req_info
    );

    modport master (
        output ic_req_valid, ic_req_info, dc_req_valid, dc_req_info,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_error,
        input  ic_rsp_valid, ic_rsp_data, ic_rsp_bus_error,
        input  dc_rsp_valid, dc_rsp_data, dc_rsp_bus_error,
        input  mem_req_valid, mem_req_info
    );
endinterface

// File: rtl/miss_mem_arbiter.sv
// Round-robin arbiter of icache/dcache miss requests onto one main-memory port.
// One request outstanding at a time; fill/ack returned as a registered one-cycle pulse.
// Optional request timeout enabled by defining MISS_ARB_TIMEOUT_EN.
module miss_mem_arbiter #(
    parameter int unsigned ADDR_W         = 20,
    parameter int unsigned LINE_W         = 128,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input logic                 clock,
    input logic                 reset,
    miss_mem_arbiter_if.slave   bus
);
    localparam int unsigned REQ_W = 1 + ADDR_W + LINE_W;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic              grant_dc_q, grant_dc_d;  // granted requester: 1 = dcache
    logic              last_dc_q, last_dc_d;    // last grant went to dcache
    logic [REQ_W-1:0]  info_q, info_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              pick_dc;

`ifdef MISS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state, grant selection and response capture
    always_comb begin
        state_d    = state_q;
        grant_dc_d = grant_dc_q;
        last_dc_d  = last_dc_q;
        info_d     = info_q;
        data_d     = data_q;
        err_d      = err_q;
        // Contention goes to whichever side did not win last time
        pick_dc    = bus.dc_req_valid && (!bus.ic_req_valid || !last_dc_q);
`ifdef MISS_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.ic_req_valid || bus.dc_req_valid) begin
                    grant_dc_d = pick_dc;
                    last_dc_d  = pick_dc;
                    info_d     = pick_dc ? bus.dc_req_info : bus.ic_req_info;
                    state_d    = StReq;
`ifdef MISS_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            StReq: begin
`ifdef MISS_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else
`endif
                if (bus.mem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
`ifdef MISS_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                // A real response wins over a timeout in the same cycle
                if (bus.mem_rsp_valid) begin
                    data_d  = bus.mem_rsp_data;
                    err_d   = bus.mem_rsp_error;
                    state_d = StDone;
                end
`ifdef MISS_ARB_TIMEOUT_EN
                else if (timeout) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_dc_q <= 1'b0;
            last_dc_q  <= 1'b0;
            info_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_dc_q <= grant_dc_d;
            last_dc_q  <= last_dc_d;
            info_q     <= info_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

`ifdef MISS_ARB_TIMEOUT_EN
    // Timeout counter over REQ+WAIT
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Outputs decode straight from registers; rsp data/error gated to zero off-pulse
    always_comb begin
        bus.mem_req_valid    = (state_q == StReq);
        bus.mem_req_info     = info_q;
        bus.ic_rsp_valid     = (state_q == StDone) && !grant_dc_q;
        bus.dc_rsp_valid     = (state_q == StDone) && grant_dc_q;
        bus.ic_rsp_data      = bus.ic_rsp_valid ? data_q : '0;
        bus.ic_rsp_bus_error = bus.ic_rsp_valid && err_q;
        bus.dc_rsp_data      = bus.dc_rsp_valid ? data_q : '0;
        bus.dc_rsp_bus_error = bus.dc_rsp_valid && err_q;
    end
endmodule

// File: tb/tb_miss_mem_arbiter.sv
// Directed self-checking bench for miss_mem_arbiter.
module tb_miss_mem_arbiter;
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned REQ_W  = 1 + ADDR_W + LINE_W;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    miss_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    miss_mem_arbiter #(
        .ADDR_W         (ADDR_W),
        .LINE_W         (LINE_W),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One transaction starting in an IDLE cycle with the requester(s) already valid.
    // Ends in the IDLE cycle after DONE, with the granted requester dropped.
    task automatic run_one(input string tag, input bit exp_dc, input logic [REQ_W-1:0] exp_info,
                           input int ready_delay, input int rsp_delay,
                           input logic [LINE_W-1:0] rdata, input bit rerr);
        int accepts = 0;
        bus.mem_req_ready = (ready_delay == 0);
        step();
        for (int i = 0; i < ready_delay; i++) begin
            checks++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_info !== exp_info) begin
                errors++;
                $display("FAIL %s req_hold[%0d] got v=%b info=%h want v=1 info=%h",
                         tag, i, bus.mem_req_valid, bus.mem_req_info, exp_info);
            end
            if (bus.mem_req_valid && bus.mem_req_ready) accepts++;
            step();
        end
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_info !== exp_info) begin
            errors++;
            $display("FAIL %s req got v=%b info=%h want v=1 info=%h",
                     tag, bus.mem_req_valid, bus.mem_req_info, exp_info);
        end
        bus.mem_req_ready = 1'b1;
        if (bus.mem_req_valid && bus.mem_req_ready) accepts++;
        step();
        checks++;
        if (accepts != 1 || bus.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s accept got accepts=%0d v=%b want accepts=1 v=0",
                     tag, accepts, bus.mem_req_valid);
        end
        for (int j = 0; j < rsp_delay; j++) begin
            checks++;
            if (bus.mem_req_valid !== 1'b0 || bus.ic_rsp_valid !== 1'b0 ||
                bus.dc_rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s wait[%0d] got mv=%b ic=%b dc=%b want 0 0 0", tag, j,
                         bus.mem_req_valid, bus.ic_rsp_valid, bus.dc_rsp_valid);
            end
            step();
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = rdata;
        bus.mem_rsp_error = rerr;
        step();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.mem_rsp_error = 1'b0;
        checks++;
        if (exp_dc) begin
            if (bus.dc_rsp_valid !== 1'b1 || bus.dc_rsp_data !== rdata ||
                bus.dc_rsp_bus_error !== rerr || bus.ic_rsp_valid !== 1'b0 ||
                bus.ic_rsp_data !== '0) begin
                errors++;
                $display("FAIL %s dc_rsp got v=%b d=%h e=%b icv=%b want v=1 d=%h e=%b icv=0", tag,
                         bus.dc_rsp_valid, bus.dc_rsp_data, bus.dc_rsp_bus_error,
                         bus.ic_rsp_valid, rdata, rerr);
            end
            bus.dc_req_valid = 1'b0;
        end else begin
            if (bus.ic_rsp_valid !== 1'b1 || bus.ic_rsp_data !== rdata ||
                bus.ic_rsp_bus_error !== rerr || bus.dc_rsp_valid !== 1'b0 ||
                bus.dc_rsp_data !== '0) begin
                errors++;
                $display("FAIL %s ic_rsp got v=%b d=%h e=%b dcv=%b want v=1 d=%h e=%b dcv=0", tag,
                         bus.ic_rsp_valid, bus.ic_rsp_data, bus.ic_rsp_bus_error,
                         bus.dc_rsp_valid, rdata, rerr);
            end
            bus.ic_req_valid = 1'b0;
        end
        step();
        checks++;
        if (bus.ic_rsp_valid !== 1'b0 || bus.dc_rsp_valid !== 1'b0 || bus.ic_rsp_data !== '0 ||
            bus.dc_rsp_data !== '0 || bus.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_end got icv=%b dcv=%b mv=%b want 0 0 0", tag,
                     bus.ic_rsp_valid, bus.dc_rsp_valid, bus.mem_req_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (bus.mem_req_valid !== 1'b0 || bus.mem_req_info !== '0 ||
            bus.ic_rsp_valid !== 1'b0 || bus.dc_rsp_valid !== 1'b0 ||
            bus.ic_rsp_data !== '0 || bus.dc_rsp_data !== '0 ||
            bus.ic_rsp_bus_error !== 1'b0 || bus.dc_rsp_bus_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got mv=%b info=%h icv=%b dcv=%b want all 0",
                     bus.mem_req_valid, bus.mem_req_info, bus.ic_rsp_valid, bus.dc_rsp_valid);
        end
        reset = 1'b0;
        step();
        checks++;
        if (bus.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req got mv=%b want 0", bus.mem_req_valid);
        end
    endtask

    task automatic test_dc_read();
        logic [REQ_W-1:0] info;
        info = {1'b0, 20'h00040, 128'h0};
        bus.dc_req_info  = info;
        bus.dc_req_valid = 1'b1;
        run_one("dc_read", 1'b1, info, 0, 3, {16{8'hA5}}, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [REQ_W-1:0] ic_info, dc_info;
        ic_info = {1'b0, 20'h01000, 128'h0};
        dc_info = {1'b0, 20'h02000, 128'h0};
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.ic_req_info  = ic_info;
        bus.dc_req_info  = dc_info;
        bus.ic_req_valid = 1'b1;
        bus.dc_req_valid = 1'b1;
        run_one("rr0_dc", 1'b1, dc_info, 0, 0, 128'h1111, 1'b0);
        bus.dc_req_valid = 1'b1;
        run_one("rr1_ic", 1'b0, ic_info, 0, 0, 128'h2222, 1'b0);
        bus.ic_req_valid = 1'b1;
        run_one("rr2_dc", 1'b1, dc_info, 0, 1, 128'h3333, 1'b0);
        bus.dc_req_valid = 1'b1;
        run_one("rr3_ic", 1'b0, ic_info, 0, 0, 128'h4444, 1'b0);
        bus.dc_req_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [REQ_W-1:0] info;
        info = {1'b0, 20'h0ABC0, 128'h0};
        bus.ic_req_info  = info;
        bus.ic_req_valid = 1'b1;
        run_one("backpressure", 1'b0, info, 10, 2, 128'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_bus_error();
        logic [REQ_W-1:0] ic_info, st_info;
        ic_info = {1'b0, 20'h00100, 128'h0};
        st_info = {1'b1, 20'h00200, {4{32'hCAFE_F00D}}};
        bus.ic_req_info  = ic_info;
        bus.ic_req_valid = 1'b1;
        run_one("ic_error", 1'b0, ic_info, 0, 1, 128'h5A5A, 1'b1);
        // Next transaction is a dcache store: error clear, ack data passed through
        bus.dc_req_info  = st_info;
        bus.dc_req_valid = 1'b1;
        run_one("dc_store_ok", 1'b1, st_info, 0, 0, 128'h77, 1'b0);
    endtask

`ifdef MISS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [REQ_W-1:0] info;
        info = {1'b0, 20'h00300, 128'h0};
        bus.ic_req_info   = info;
        bus.ic_req_valid  = 1'b1;
        bus.mem_req_ready = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (bus.ic_rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early[%0d] got icv=%b want 0", i, bus.ic_rsp_valid);
            end
            step();
        end
        step();
        checks++;
        if (bus.ic_rsp_valid !== 1'b1 || bus.ic_rsp_bus_error !== 1'b1 ||
            bus.ic_rsp_data !== '0) begin
            errors++;
            $display("FAIL timeout_rsp got v=%b e=%b d=%h want v=1 e=1 d=0",
                     bus.ic_rsp_valid, bus.ic_rsp_bus_error, bus.ic_rsp_data);
        end
        bus.ic_req_valid = 1'b0;
        step();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 128'hBAD;
        step();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        step();
        checks++;
        if (bus.mem_req_valid !== 1'b0 || bus.ic_rsp_valid !== 1'b0 ||
            bus.dc_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_late_rsp got mv=%b icv=%b dcv=%b want 0 0 0",
                     bus.mem_req_valid, bus.ic_rsp_valid, bus.dc_rsp_valid);
        end
    endtask
`endif

    task automatic test_reset_in_wait();
        logic [REQ_W-1:0] info, info2;
        info  = {1'b0, 20'h00400, 128'h0};
        info2 = {1'b0, 20'h00500, 128'h0};
        bus.dc_req_info   = info;
        bus.dc_req_valid  = 1'b1;
        bus.mem_req_ready = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        checks++;
        if (bus.mem_req_valid !== 1'b0 || bus.mem_req_info !== '0 ||
            bus.ic_rsp_valid !== 1'b0 || bus.dc_rsp_valid !== 1'b0 ||
            bus.dc_rsp_data !== '0 || bus.dc_rsp_bus_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait got mv=%b info=%h icv=%b dcv=%b want all 0",
                     bus.mem_req_valid, bus.mem_req_info, bus.ic_rsp_valid, bus.dc_rsp_valid);
        end
        reset = 1'b0;
        bus.dc_req_valid = 1'b0;
        step();
        checks++;
        if (bus.dc_rsp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pulse got dcv=%b mv=%b want 0 0",
                     bus.dc_rsp_valid, bus.mem_req_valid);
        end
        bus.dc_req_info  = info2;
        bus.dc_req_valid = 1'b1;
        run_one("after_reset", 1'b1, info2, 0, 0, 128'h0F0F, 1'b0);
    endtask

    initial begin
        bus.ic_req_valid  = 1'b0;
        bus.ic_req_info   = '0;
        bus.dc_req_valid  = 1'b0;
        bus.dc_req_info   = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.mem_rsp_error = 1'b0;
        test_reset();
        test_dc_read();
        test_round_robin();
        test_backpressure();
        test_bus_error();
`ifdef MISS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
